enigma_cipher_path: RTL

- Consumer end of the rotor-stepping interface: drives a one-cycle `rotate` pulse to the rotor controller and reads back the three rotor positions.
- Enciphers one key letter per request: rotor3 -> rotor2 -> rotor1 -> reflector -> rotor1 -> rotor2 -> rotor3.
- Multi-cycle FSM, one substitution stage per cycle.
- Sits between keyboard/UART letter input and display/lamp output.

---
 rtl/enigma_pkg.sv | 67 ++++++
 rtl/enigma_cipher_path_if.sv | 24 ++
 rtl/enigma_rotor_map.sv | 37 +++
 rtl/enigma_cipher_path.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma cipher path: wiring tables, encodings,
// mod-26 arithmetic and the FSM state type.
package enigma_pkg;

  localparam int LETTERS = 26;

  typedef logic [4:0] tbl_t [LETTERS];

  typedef enum logic [2:0] {
    ROTOR_I   = 3'd0,
    ROTOR_II  = 3'd1,
    ROTOR_III = 3'd2,
    ROTOR_IV  = 3'd3,
    ROTOR_V   = 3'd4
  } rotor_type_e;

  typedef enum logic {
    REFLECTOR_B = 1'b0,
    REFLECTOR_C = 1'b1
  } reflector_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STEP   = 3'd1,
    SETTLE = 3'd2,
    PASS   = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Configuration frozen at the end of SETTLE so the in-flight letter is stable.
  typedef struct packed {
    logic [4:0] pos1;
    logic [4:0] pos2;
    logic [4:0] pos3;
    logic [2:0] type1;
    logic [2:0] type2;
    logic [2:0] type3;
    logic [4:0] ring1;
    logic [4:0] ring2;
    logic [4:0] ring3;
    logic       refl;
  } rotor_cfg_t;

  localparam tbl_t WIRE_I   = '{4,10,12,5,11,6,3,16,21,25,13,19,14,22,24,7,23,20,18,15,0,8,1,17,2,9};
  localparam tbl_t WIRE_II  = '{0,9,3,10,18,8,17,20,23,1,11,7,22,19,12,2,16,6,25,13,15,24,5,21,14,4};
  localparam tbl_t WIRE_III = '{1,3,5,7,9,11,2,15,17,19,23,21,25,13,24,4,8,22,6,0,10,12,20,18,16,14};
  localparam tbl_t WIRE_IV  = '{4,18,14,21,15,25,9,0,24,16,20,8,17,7,23,11,13,5,19,6,10,3,2,12,22,1};
  localparam tbl_t WIRE_V   = '{21,25,1,17,6,8,19,24,20,15,18,3,13,7,11,23,0,22,12,9,16,14,5,4,2,10};
  localparam tbl_t WIRE_REF_B = '{24,17,20,7,16,18,11,3,15,23,13,6,14,10,12,8,4,1,5,25,2,22,21,9,0,19};
  localparam tbl_t WIRE_REF_C = '{5,21,15,9,8,0,14,24,4,3,17,25,23,22,6,2,19,10,20,16,18,1,13,12,7,11};

  // Operands are always 0..25, so one conditional correction is enough.
  function automatic logic [4:0] mod26_add(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  function automatic logic [4:0] mod26_sub(input logic [4:0] a, input logic [4:0] b);
    logic signed [5:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = d + 6'sd26;
    return d[4:0];
  endfunction

endpackage

// File: rtl/enigma_cipher_path_if.sv
// Key-request / cipher-output / rotor-stepping signal bundle.
// Handshake: a key transfers on a rising edge with key_valid=1 and key_ready=1;
// rotate and out_valid are single-cycle strobes with no back-pressure.
interface enigma_cipher_path_if;
  logic       key_valid;
  logic [4:0] key_in;
  logic       key_ready;
  logic       rotate;
  logic [4:0] rotor1;
  logic [4:0] rotor2;
  logic [4:0] rotor3;
  logic       out_valid;
  logic [4:0] out_letter;

  modport master (
    output key_valid, key_in, rotor1, rotor2, rotor3,
    input  key_ready, rotate, out_valid, out_letter
  );

  modport slave (
    input  key_valid, key_in, rotor1, rotor2, rotor3,
    output key_ready, rotate, out_valid, out_letter
  );
endinterface

// File: rtl/enigma_rotor_map.sv
// Single rotor substitution, forward or inverse, including position and ring offset.
module enigma_rotor_map
  import enigma_pkg::*;
(
  input  logic [4:0] letter,
  input  logic [4:0] pos,
  input  logic [4:0] ring,
  input  logic [2:0] rtype,
  input  logic       dir_inv,
  output logic [4:0] letter_out
);

  tbl_t       wiring;
  logic [4:0] c;
  logic [4:0] w;

  always_comb begin
    case (rtype)
      ROTOR_II:  wiring = WIRE_II;
      ROTOR_III: wiring = WIRE_III;
      ROTOR_IV:  wiring = WIRE_IV;
      ROTOR_V:   wiring = WIRE_V;
      default:   wiring = WIRE_I;
    endcase
    c = mod26_sub(mod26_add(letter, pos), ring);
    w = wiring[c];
    // Inverse wiring is a reverse search of the forward table.
    if (dir_inv) begin
      w = '0;
      for (int i = 0; i < LETTERS; i++) begin
        if (wiring[i] == c) w = 5'(i);
      end
    end
    letter_out = mod26_add(mod26_sub(w, pos), ring);
  end

endmodule

// File: rtl/enigma_cipher_path.sv
// Enigma cipher path: steps the rotors, snapshots configuration, then runs one
// substitution stage per cycle. ENIGMA_PLUGBOARD_EN adds plugboard in/out stages.
module enigma_cipher_path
  import enigma_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  enigma_cipher_path_if.slave kif,
  input  logic [2:0] rotor_type_1,
  input  logic [2:0] rotor_type_2,
  input  logic [2:0] rotor_type_3,
  input  logic [4:0] ring_position_1,
  input  logic [4:0] ring_position_2,
  input  logic [4:0] ring_position_3,
  input  logic       reflector_type,
`ifdef ENIGMA_PLUGBOARD_EN
  input  logic [129:0] plug_map,
`endif
  output state_e     dbg_state
);

`ifdef ENIGMA_PLUGBOARD_EN
  localparam logic [3:0] STAGE_OFS  = 4'd1;
  localparam logic [3:0] LAST_STAGE = 4'd8;
`else
  localparam logic [3:0] STAGE_OFS  = 4'd0;
  localparam logic [3:0] LAST_STAGE = 4'd6;
`endif
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] stage_q, stage_d;
  logic [4:0] letter_q, letter_d;
  logic [4:0] out_letter_q, out_letter_d;
  rotor_cfg_t cfg_q, cfg_d;
`ifdef ENIGMA_PLUGBOARD_EN
  logic [129:0] plug_q, plug_d;
  logic [4:0]   plug_letter;
`endif

  logic [3:0] rs;
  logic [4:0] map_pos, map_ring, map_out, refl_letter, stage_letter;
  logic [2:0] map_type;
  logic       map_inv;

  // Rotor stage index: 0-2 forward r3/r2/r1, 3 reflector, 4-6 inverse r1/r2/r3.
  assign rs = stage_q - STAGE_OFS;

  always_comb begin
    map_pos  = cfg_q.pos3;
    map_ring = cfg_q.ring3;
    map_type = cfg_q.type3;
    case (rs)
      4'd1, 4'd5: begin
        map_pos  = cfg_q.pos2;
        map_ring = cfg_q.ring2;
        map_type = cfg_q.type2;
      end
      4'd2, 4'd4: begin
        map_pos  = cfg_q.pos1;
        map_ring = cfg_q.ring1;
        map_type = cfg_q.type1;
      end
      default: ;
    endcase
    map_inv = (rs >= 4'd4);
  end

  enigma_rotor_map u_rotor_map (
    .letter     (letter_q),
    .pos        (map_pos),
    .ring       (map_ring),
    .rtype      (map_type),
    .dir_inv    (map_inv),
    .letter_out (map_out)
  );

  assign refl_letter = (cfg_q.refl == REFLECTOR_C) ? WIRE_REF_C[letter_q] : WIRE_REF_B[letter_q];

`ifdef ENIGMA_PLUGBOARD_EN
  always_comb begin
    plug_letter = letter_q;
    for (int i = 0; i < LETTERS; i++) begin
      if (letter_q == 5'(i)) plug_letter = plug_q[i*5 +: 5];
    end
  end
`endif

  always_comb begin
    stage_letter = (rs == 4'd3) ? refl_letter : map_out;
`ifdef ENIGMA_PLUGBOARD_EN
    if (stage_q == 4'd0 || stage_q == LAST_STAGE) stage_letter = plug_letter;
`endif
  end

  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    letter_d     = letter_q;
    out_letter_d = out_letter_q;
    cfg_d        = cfg_q;
`ifdef ENIGMA_PLUGBOARD_EN
    plug_d       = plug_q;
`endif
    case (state_q)
      IDLE: begin
        if (kif.key_valid && (kif.key_in < 5'(LETTERS))) begin
          letter_d = kif.key_in;
          state_d  = STEP;
        end
      end
      STEP: begin
        stage_d = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (stage_q == SETTLE_LAST) begin
          cfg_d = '{pos1: kif.rotor1, pos2: kif.rotor2, pos3: kif.rotor3,
                    type1: rotor_type_1, type2: rotor_type_2, type3: rotor_type_3,
                    ring1: ring_position_1, ring2: ring_position_2, ring3: ring_position_3,
                    refl: reflector_type};
`ifdef ENIGMA_PLUGBOARD_EN
          plug_d = plug_map;
`endif
          stage_d = '0;
          state_d = PASS;
        end else begin
          stage_d = stage_q + 4'd1;
        end
      end
      PASS: begin
        letter_d = stage_letter;
        if (stage_q == LAST_STAGE) begin
          out_letter_d = stage_letter;
          stage_d      = '0;
          state_d      = DONE;
        end else begin
          stage_d = stage_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      stage_q      <= '0;
      letter_q     <= '0;
      out_letter_q <= '0;
      cfg_q        <= '0;
`ifdef ENIGMA_PLUGBOARD_EN
      plug_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      letter_q     <= letter_d;
      out_letter_q <= out_letter_d;
      cfg_q        <= cfg_d;
`ifdef ENIGMA_PLUGBOARD_EN
      plug_q       <= plug_d;
`endif
    end
  end

  assign kif.key_ready  = (state_q == IDLE);
  assign kif.rotate     = (state_q == STEP);
  assign kif.out_valid  = (state_q == DONE);
  assign kif.out_letter = out_letter_q;
  assign dbg_state      = state_q;

endmodule
